// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB phase sequencer with memory
//            handshakes, HALT, fetch/mem watchdog and retired-instruction count.
//            Optional single-step mode: define INSTR_SEQ_SINGLE_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter logic [4:0] OP_LOAD  = 5'b01010,
    parameter logic [4:0] OP_STORE = 5'b01011,
    parameter logic [4:0] OP_HALT  = 5'b11111,
    parameter int         TIMEOUT  = 16,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic [4:0]       op,
    input  logic             fetch_ack,
    input  logic             mem_ack,
    output logic             fetch_req,
    output logic             mem_req,
    output logic             mem_we,
    output logic             t_fetch,
    output logic             t_decode,
    output logic             t_exec,
    output logic             t_mem,
    output logic             t_wb,
    output logic             reg_we,
    output logic             pc_inc,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [2:0]       state
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_mem    = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_halt   = 3'd6;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    localparam logic [2:0] c_st_pause  = 3'd7;
    localparam logic [2:0] c_st_after_wb = c_st_pause;
`else
    localparam logic [2:0] c_st_after_wb = c_st_fetch;
`endif

    localparam int               c_wait_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit               c_wdog_en   = (TIMEOUT > 0);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]          r_state;
    logic [4:0]          r_op_q;
    logic [c_wait_w-1:0] r_wait;
    logic [2:0]          w_next_state;
    logic [4:0]          w_next_op;
    logic [c_wait_w-1:0] w_next_wait;
    logic                w_timeout;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    logic                r_step_d;
`endif

    assign state = r_state;

    // Wait counter is zero outside FETCH/MEM, so entering either starts from 0.
    always_comb begin
        w_next_state = r_state;
        w_next_op    = r_op_q;
        w_next_wait  = '0;
        w_timeout    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) w_next_state = c_st_fetch;
            end
            c_st_fetch: begin
                if (fetch_ack) begin
                    w_next_state = c_st_decode;
                end else if (c_wdog_en && (r_wait == c_wait_last)) begin
                    w_timeout    = 1'b1;
                    w_next_state = c_st_halt;
                end else begin
                    w_next_wait = r_wait + c_wait_w'(1);
                end
            end
            c_st_decode: begin
                w_next_op    = op;
                w_next_state = (op == OP_HALT) ? c_st_halt : c_st_exec;
            end
            c_st_exec: begin
                w_next_state = ((r_op_q == OP_LOAD) || (r_op_q == OP_STORE)) ? c_st_mem : c_st_wb;
            end
            c_st_mem: begin
                if (mem_ack) begin
                    w_next_state = c_st_wb;
                end else if (c_wdog_en && (r_wait == c_wait_last)) begin
                    w_timeout    = 1'b1;
                    w_next_state = c_st_halt;
                end else begin
                    w_next_wait = r_wait + c_wait_w'(1);
                end
            end
            c_st_wb: begin
                w_next_state = c_st_after_wb;
            end
            c_st_halt: begin
                w_next_state = c_st_halt;
            end
`ifdef INSTR_SEQ_SINGLE_STEP_EN
            c_st_pause: begin
                if (step && !r_step_d) w_next_state = c_st_fetch;
            end
`endif
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state
    // while still coming straight out of flops; async reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_op_q      <= '0;
            r_wait      <= '0;
            timeout_err <= 1'b0;
            instr_cnt   <= '0;
            fetch_req   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            t_fetch     <= 1'b0;
            t_decode    <= 1'b0;
            t_exec      <= 1'b0;
            t_mem       <= 1'b0;
            t_wb        <= 1'b0;
            reg_we      <= 1'b0;
            pc_inc      <= 1'b0;
            halted      <= 1'b0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
            r_step_d    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_op_q  <= w_next_op;
            r_wait  <= w_next_wait;
            if (w_timeout) timeout_err <= 1'b1;
            if (r_state == c_st_wb) instr_cnt <= instr_cnt + CNT_W'(1);
            fetch_req <= (w_next_state == c_st_fetch);
            t_fetch   <= (w_next_state == c_st_fetch);
            t_decode  <= (w_next_state == c_st_decode);
            t_exec    <= (w_next_state == c_st_exec);
            mem_req   <= (w_next_state == c_st_mem);
            t_mem     <= (w_next_state == c_st_mem);
            mem_we    <= (w_next_state == c_st_mem) && (w_next_op == OP_STORE);
            t_wb      <= (w_next_state == c_st_wb);
            pc_inc    <= (w_next_state == c_st_wb);
            reg_we    <= (w_next_state == c_st_wb) && (w_next_op != OP_STORE);
            halted    <= (w_next_state == c_st_halt);
`ifdef INSTR_SEQ_SINGLE_STEP_EN
            r_step_d  <= step;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Directed self-checking bench for instr_sequencer (CNT_W=4,
//            TIMEOUT=16). Step-mode checks apply when INSTR_SEQ_SINGLE_STEP_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam logic [4:0] c_add   = 5'b00001;
    localparam logic [4:0] c_load  = 5'b01010;
    localparam logic [4:0] c_store = 5'b01011;
    localparam logic [4:0] c_halt  = 5'b11111;

    // {t_fetch,t_decode,t_exec,t_mem,t_wb,fetch_req,mem_req,pc_inc,halted}
    localparam logic [8:0] c_v_idle   = 9'b00000_0000;
    localparam logic [8:0] c_v_fetch  = 9'b10000_1000;
    localparam logic [8:0] c_v_decode = 9'b01000_0000;
    localparam logic [8:0] c_v_exec   = 9'b00100_0000;
    localparam logic [8:0] c_v_mem    = 9'b00010_0100;
    localparam logic [8:0] c_v_wb     = 9'b00001_0010;
    localparam logic [8:0] c_v_halt   = 9'b00000_0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] op;
    logic       fetch_ack;
    logic       mem_ack;
    logic       fetch_req, mem_req, mem_we;
    logic       t_fetch, t_decode, t_exec, t_mem, t_wb;
    logic       reg_we, pc_inc, halted, timeout_err;
    logic [3:0] instr_cnt;
    logic [2:0] state;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    logic       step;
`endif

    int         n_total = 0;
    int         n_pass  = 0;
    logic [3:0] exp_cnt;

    always #5 clk = ~clk;

    instr_sequencer #(
        .TIMEOUT (16),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .start       (start),
        .op          (op),
        .fetch_ack   (fetch_ack),
        .mem_ack     (mem_ack),
        .fetch_req   (fetch_req),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .t_fetch     (t_fetch),
        .t_decode    (t_decode),
        .t_exec      (t_exec),
        .t_mem       (t_mem),
        .t_wb        (t_wb),
        .reg_we      (reg_we),
        .pc_inc      (pc_inc),
        .halted      (halted),
        .timeout_err (timeout_err),
        .instr_cnt   (instr_cnt),
        .state       (state)
    );

    function automatic logic [8:0] vec();
        return {t_fetch, t_decode, t_exec, t_mem, t_wb, fetch_req, mem_req, pc_inc, halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st, input logic [8:0] v);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_strobes"}, 32'(vec()), 32'(v));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at the negedge right after leaving WB.
    task automatic after_wb();
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        chk_st("pause", 3'd7, c_v_idle);
        tick();
        chk_st("pause_hold", 3'd7, c_v_idle);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
`endif
    endtask

    // Entered at a FETCH negedge; leaves at the DECODE negedge.
    task automatic do_fetch(input logic [4:0] o);
        chk_st("fetch", 3'd1, c_v_fetch);
        fetch_ack = 1'b1;
        op        = o;
        tick();
        fetch_ack = 1'b0;
    endtask

    task automatic do_alu();
        do_fetch(c_add);
        chk_st("alu_decode", 3'd2, c_v_decode);
        tick();
        chk_st("alu_exec", 3'd3, c_v_exec);
        tick();
        chk_st("alu_wb", 3'd5, c_v_wb);
        chk("alu_reg_we", 32'(reg_we), 1);
        tick();
        exp_cnt = exp_cnt + 4'd1;
        chk("alu_cnt", 32'(instr_cnt), 32'(exp_cnt));
        after_wb();
    endtask

    task automatic do_mem(input logic [4:0] o, input int waits);
        do_fetch(o);
        chk_st("mem_decode", 3'd2, c_v_decode);
        tick();
        chk_st("mem_exec", 3'd3, c_v_exec);
        tick();
        for (int k = 0; k <= waits; k++) begin
            chk_st("mem_mem", 3'd4, c_v_mem);
            chk("mem_we", 32'(mem_we), (o == c_store) ? 1 : 0);
            if (k == waits) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk_st("mem_wb", 3'd5, c_v_wb);
        chk("mem_reg_we", 32'(reg_we), (o == c_store) ? 0 : 1);
        tick();
        exp_cnt = exp_cnt + 4'd1;
        chk("mem_cnt", 32'(instr_cnt), 32'(exp_cnt));
        after_wb();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = '0;
        fetch_ack = 1'b0;
        mem_ack   = 1'b0;
        exp_cnt   = '0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        step      = 1'b0;
`endif
        tick();
        tick();
        chk_st("reset", 3'd0, c_v_idle);
        chk("reset_cnt", 32'(instr_cnt), 0);
        chk("reset_err", 32'(timeout_err), 0);
        chk("reset_we", 32'({reg_we, mem_we}), 0);

        rst_n = 1'b1;
        tick();
        chk_st("idle_wait", 3'd0, c_v_idle);
        start = 1'b1;
        tick();
        start = 1'b0;
        do_alu();

        do_mem(c_load, 3);
        do_mem(c_store, 1);

        // Fetch ack arrives on exactly the 16th FETCH cycle: no error.
        for (int k = 1; k <= 16; k++) begin
            chk_st("late_fetch", 3'd1, c_v_fetch);
            if (k == 16) begin
                fetch_ack = 1'b1;
                op        = c_add;
            end
            tick();
        end
        fetch_ack = 1'b0;
        chk("late_err", 32'(timeout_err), 0);
        chk_st("late_decode", 3'd2, c_v_decode);
        tick();
        chk_st("late_exec", 3'd3, c_v_exec);
        tick();
        chk_st("late_wb", 3'd5, c_v_wb);
        tick();
        exp_cnt = exp_cnt + 4'd1;
        chk("late_cnt", 32'(instr_cnt), 32'(exp_cnt));
        after_wb();

        // Counter wrap 15 -> 0.
        while (exp_cnt != 4'd15) do_alu();
        do_alu();
        chk("wrap", 32'(instr_cnt), 0);

        // Asynchronous reset in the middle of a MEM wait.
        do_fetch(c_load);
        tick();
        tick();
        chk("pre_rst_mem_req", 32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req), 0);
        chk("async_state", 32'(state), 0);
        chk("async_cnt", 32'(instr_cnt), 0);
        chk("async_t_mem", 32'(t_mem), 0);
        tick();
        rst_n   = 1'b1;
        exp_cnt = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        do_alu();

        // Fetch ack never arrives: watchdog trips after 16 FETCH cycles.
        for (int k = 1; k <= 16; k++) begin
            chk_st("to_fetch", 3'd1, c_v_fetch);
            chk("to_err_early", 32'(timeout_err), 0);
            tick();
        end
        chk_st("to_halt", 3'd6, c_v_halt);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_cnt", 32'(instr_cnt), 1);

        // HALT opcode after a fresh reset; HALT ignores everything.
        rst_n = 1'b0;
        tick();
        chk("rst_err_clear", 32'(timeout_err), 0);
        rst_n   = 1'b1;
        exp_cnt = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        do_fetch(c_halt);
        chk_st("halt_decode", 3'd2, c_v_decode);
        tick();
        for (int k = 0; k < 6; k++) begin
            chk_st("halt", 3'd6, c_v_halt);
            chk("halt_cnt", 32'(instr_cnt), 0);
            start     = k[0];
            fetch_ack = 1'b1;
            mem_ack   = 1'b1;
            tick();
        end
        start     = 1'b0;
        fetch_ack = 1'b0;
        mem_ack   = 1'b0;
        chk_st("halt_final", 3'd6, c_v_halt);
        chk("halt_err", 32'(timeout_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
